// File: rtl/k_counter_filter.sv
// rtl/k_counter_filter.sv - DPLL K-counter loop filter with carry/borrow pulses and lock detect
module k_counter_filter #(
    parameter int MAX_KW   = 16,
    parameter int LOCK_WIN = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              dn_up,
    input  logic [4:0]        k_sel,
    output logic              carry,
    output logic              borrow,
    output logic              locked,
    output logic [MAX_KW-1:0] up_cnt,
    output logic [MAX_KW-1:0] dn_cnt
);

    localparam int              LCW      = $clog2(LOCK_WIN + 1);
    localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_WIN);
    localparam logic [4:0]      K_MIN    = 5'd3;
    localparam logic [4:0]      K_MAX    = 5'(MAX_KW);

    logic              dn_up_r;
    logic [4:0]        k_eff;
    logic [LCW-1:0]    lock_cnt;

    logic [4:0]        k_clamped;
    logic [MAX_KW-1:0] k_mask;
    logic              up_wrap;
    logic              dn_wrap;
    logic              wrap;
    logic [LCW-1:0]    lock_next;

    // Clamp the requested modulus exponent and derive the wrap conditions for the active K.
    always_comb begin
        k_clamped = k_sel;
        if (k_sel < K_MIN) begin
            k_clamped = K_MIN;
        end else if (k_sel > K_MAX) begin
            k_clamped = K_MAX;
        end
        k_mask    = ~({MAX_KW{1'b1}} << k_eff);
        up_wrap   = !dn_up_r && (up_cnt == k_mask);
        dn_wrap   = dn_up_r && (dn_cnt == k_mask);
        wrap      = up_wrap || dn_wrap;
        lock_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LCW'(1);
    end

    // Phase-error registration, modulus tracking, counting, pulse generation and lock detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dn_up_r  <= 1'b0;
            k_eff    <= K_MIN;
            up_cnt   <= '0;
            dn_cnt   <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            dn_up_r <= dn_up;
            if (k_clamped != k_eff) begin
                // A new modulus restarts integration from scratch and discards lock history.
                k_eff    <= k_clamped;
                up_cnt   <= '0;
                dn_cnt   <= '0;
                carry    <= 1'b0;
                borrow   <= 1'b0;
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else if (en) begin
                carry  <= up_wrap;
                borrow <= dn_wrap;
                if (!dn_up_r) begin
                    up_cnt <= up_wrap ? '0 : up_cnt + MAX_KW'(1);
                end else begin
                    dn_cnt <= dn_wrap ? '0 : dn_cnt + MAX_KW'(1);
                end
                if (wrap) begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end else begin
                    lock_cnt <= lock_next;
                    locked   <= (lock_next == LOCK_MAX);
                end
            end else begin
                carry  <= 1'b0;
                borrow <= 1'b0;
            end
        end
    end

endmodule
